mem_access_unit: RTL and testbench

- Responder side of the pipeline memory-stall handshake.
- The hazard unit raises a stall when a load/store enters the pipe and holds it until `wb_done_i`; this block services that access.
- It captures the MEM-stage load/store, runs a multi-cycle req/ack transaction on the data-memory bus, and aligns and extends load data.
- It then emits the one-cycle `done_o` pulse that releases the stall.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_access_unit_if.sv | 17 +
 rtl/mem_access_unit_load_align.sv | 28 ++
 rtl/mem_access_unit.sv | 115 +++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: opcodes, FSM encoding
// and opcode classification helpers.
package mem_pkg;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SB  = 6'b101000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == LW) || (op == LB) || (op == LBU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == SW) || (op == SB);
  endfunction

  function automatic logic is_byte(input logic [5:0] op);
    return (op == LB) || (op == LBU) || (op == SB);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and memory (slave):
// a held request completed by a single-cycle ack carrying read data.
interface mem_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        be;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte lane out of a read word and sign/zero extends it;
// non-load opcodes produce zero.
module load_align
  import mem_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0] lane;

  always_comb begin
    lane = word[{byte_sel, 3'b000} +: 8];
  end

  always_comb begin
    result = '0;
    case (opcode)
      LW:      result = word;
      LB:      result = {{24{lane[7]}}, lane};
      LBU:     result = {24'h0, lane};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Services a stalled MEM-stage load/store over the req/ack bus and pulses done_o.
// Build option MEM_TIMEOUT_EN: abort an unacknowledged request after TIMEOUT cycles.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic [5:0]        mem_opcode_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              busy_o,
  mem_bus_if.master         bus
);

  state_t            state_q, state_d;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] aligned;
  logic              capture;
  logic              misalign;
  logic              timeout_hit;
  logic              in_req;

  assign capture  = (state_q == IDLE) && mem_valid_i &&
                    (is_load(mem_opcode_i) || is_store(mem_opcode_i));
  assign misalign = !is_byte(mem_opcode_i) && (mem_addr_i[1:0] != 2'b00);
  assign in_req   = (state_q == REQ);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt_q <= '0;
    else if (!in_req)        cnt_q <= '0;
    else if (!bus.ack)       cnt_q <= cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: if (capture) state_d = misalign ? DONE : REQ;
      REQ: begin
        if (bus.ack) begin
          state_d = DONE;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // ack on this same edge would have taken the branch above
          state_d     = DONE;
          timeout_hit = 1'b1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        op_q    <= mem_opcode_i;
        addr_q  <= mem_addr_i;
        wdata_q <= mem_wdata_i;
        rdata_q <= '0;
        err_q   <= misalign;
      end
      if (in_req && bus.ack) rdata_q <= aligned;
      if (timeout_hit)       err_q   <= 1'b1;
    end
  end

  load_align u_load_align (
    .opcode   (op_q),
    .byte_sel (addr_q[1:0]),
    .word     (bus.rdata),
    .result   (aligned)
  );

  // Bus fields are held from the captured request and forced to zero outside REQ.
  assign bus.req   = in_req;
  assign bus.we    = in_req && is_store(op_q);
  assign bus.addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.wdata = !in_req      ? '0 :
                     (op_q == SB) ? {4{wdata_q[7:0]}} : wdata_q;
  assign bus.be    = !in_req       ? 4'b0000 :
                     is_byte(op_q) ? (4'b0001 << addr_q[1:0]) : 4'b1111;

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign err_o   = done_o && err_q;
  assign rdata_o = (done_o && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed vector bench for mem_access_unit plus reset/idle/timeout sequences.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [5:0]  mem_opcode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mem_bus_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid_i  (mem_valid),
    .mem_opcode_i (mem_opcode),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
    .done_o       (done),
    .rdata_o      (rdata),
    .err_o        (err),
    .busy_o       (busy),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          waits;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic        we;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          nreq;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  edges;
    int  nreq;
    bit  seen;
    edges = 0;
    nreq  = 0;
    seen  = 0;
    @(negedge clk);
    mem_valid  = 1'b1;
    mem_opcode = v.op;
    mem_addr   = v.addr;
    mem_wdata  = v.wdata;
    @(posedge clk);
    #1 mem_valid = 1'b0;
    mem_opcode = 6'd0;
    while (!seen && edges < 200) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk($sformatf("v%0d_latency", idx), edges, v.lat);
        chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
      end
      if (bus.req) begin
        nreq++;
        if (nreq == 1) begin
          chk($sformatf("v%0d_be", idx), {28'd0, bus.be}, {28'd0, v.be});
          chk($sformatf("v%0d_addr", idx), bus.addr, v.baddr);
          chk($sformatf("v%0d_wdata", idx), bus.wdata, v.bwdata);
          chk($sformatf("v%0d_we", idx), {31'd0, bus.we}, {31'd0, v.we});
        end
        bus.rdata = v.bus_rdata;
        bus.ack   = (nreq == v.waits + 1);
      end else begin
        bus.ack = 1'b0;
      end
      @(posedge clk);
      #1 bus.ack = 1'b0;
      edges++;
    end
    if (!seen) chk($sformatf("v%0d_done_seen", idx), 32'd0, 32'd1);
    chk($sformatf("v%0d_req_cycles", idx), nreq, v.nreq);
    @(negedge clk);
    chk($sformatf("v%0d_done_single", idx), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d_idle_after", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    int nbusy;
    int nreq;
    bit seen;

    vecs[0] = '{LW,  32'h100, 32'h0,        32'hDEADBEEF, 2, 4'b1111, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 3, 3};
    vecs[1] = '{LB,  32'h203, 32'h0,        32'h80123456, 0, 4'b1000, 32'h200, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0, 1, 1};
    vecs[2] = '{LBU, 32'h203, 32'h0,        32'h80123456, 0, 4'b1000, 32'h200, 32'h0,        1'b0, 32'h00000080, 1'b0, 1, 1};
    vecs[3] = '{SB,  32'h301, 32'h000000AB, 32'h55555555, 0, 4'b0010, 32'h300, 32'hABABABAB, 1'b1, 32'h0,        1'b0, 1, 1};
    vecs[4] = '{SW,  32'h402, 32'h12345678, 32'h0,        0, 4'b0000, 32'h0,   32'h0,        1'b0, 32'h0,        1'b1, 0, 0};
    vecs[5] = '{SW,  32'h500, 32'h12345678, 32'hFFFFFFFF, 1, 4'b1111, 32'h500, 32'h12345678, 1'b1, 32'h0,        1'b0, 2, 2};
    vecs[6] = '{LB,  32'h600, 32'h0,        32'h1122337F, 0, 4'b0001, 32'h600, 32'h0,        1'b0, 32'h0000007F, 1'b0, 1, 1};
    vecs[7] = '{LBU, 32'h702, 32'h0,        32'h00C50000, 1, 4'b0100, 32'h700, 32'h0,        1'b0, 32'h000000C5, 1'b0, 2, 2};
    vecs[8] = '{LW,  32'h801, 32'h0,        32'hCAFEF00D, 0, 4'b0000, 32'h0,   32'h0,        1'b0, 32'h0,        1'b1, 0, 0};
    vecs[9] = '{LB,  32'h902, 32'h0,        32'h00A50000, 3, 4'b0100, 32'h900, 32'h0,        1'b0, 32'hFFFFFFA5, 1'b0, 4, 4};

    rst        = 1'b1;
    mem_valid  = 1'b0;
    mem_opcode = 6'd0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    bus.ack    = 1'b0;
    bus.rdata  = 32'd0;

    #3;
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_err",   {31'd0, err},  32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_req",   {31'd0, bus.req}, 32'd0);
    chk("rst_be",    {28'd0, bus.be}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // unsupported opcode and valid low must never start an access
    nbusy = 0;
    @(negedge clk);
    mem_valid  = 1'b1;
    mem_opcode = 6'b000000;
    mem_addr   = 32'h100;
    repeat (4) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    mem_valid  = 1'b0;
    mem_opcode = LW;
    repeat (3) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    mem_opcode = 6'd0;
    chk("ignore_unsupported", nbusy, 0);

    // reset in the middle of REQ
    @(negedge clk);
    mem_valid  = 1'b1;
    mem_opcode = LW;
    mem_addr   = 32'hA00;
    @(posedge clk);
    #1 mem_valid = 1'b0;
    mem_opcode = 6'd0;
    @(negedge clk);
    chk("midreq_req_before", {31'd0, bus.req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midreq_req_async",  {31'd0, bus.req}, 32'd0);
    chk("midreq_busy_async", {31'd0, busy}, 32'd0);
    chk("midreq_done_async", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      bus.ack   = i[0];
      bus.rdata = 32'h12345678;
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    bus.ack = 1'b0;
    chk("midreq_no_done", ndone, 0);
    chk("midreq_stay_idle", nbusy, 0);

    // request that is never acknowledged
    @(negedge clk);
    mem_valid  = 1'b1;
    mem_opcode = LW;
    mem_addr   = 32'hB00;
    @(posedge clk);
    #1 mem_valid = 1'b0;
    mem_opcode = 6'd0;
    nreq  = 0;
    ndone = 0;
    seen  = 0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.req) nreq++;
      if (done) begin
        seen = 1;
        chk("timeout_err",   {31'd0, err}, 32'd1);
        chk("timeout_rdata", rdata, 32'd0);
      end
    end
    if (!seen) chk("timeout_done_seen", 32'd0, 32'd1);
    chk("timeout_req_cycles", nreq, 16);
`else
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (bus.req) nreq++;
      if (done) ndone++;
    end
    chk("noack_req_held", nreq, 120);
    chk("noack_no_done", ndone, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    @(negedge clk);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
